// File: rtl/qtr_sched.sv
// qtr_sched: periodic trigger/collect scheduler for two QTR reflectance sensor stages.
//
// A free-running prescaler produces a one-cycle ms_tick. Each sample fires both
// sensor stages together, collects one result per channel, and then commits the
// pair to sample0/1 together with the threshold detect bits. If a channel does not
// answer within TIMEOUT_MS ms, that channel commits as 255 and timeout_err sets.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   enable                level, periodic sampling runs while 1
//   period[7:0]           sample period in ms (0 behaves as 1)
//   thresh0/1[7:0]        detect thresholds
//   clear_err             pulse, clears timeout_err
//   qtr_en0/1             one-cycle start pulse to each sensor stage
//   value0/1[7:0], valid0/1  result and strobe from each sensor stage
//   sample0/1[7:0]        last committed values
//   detect[1:0]           bit n = sampleN >= threshN
//   update                one-cycle pulse, aligned with new sample/detect
//   timeout_err           sticky timeout flag
module qtr_sched #(
    parameter int CLK_FREQUENCY = 60_000_000,
    parameter int TIMEOUT_MS    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] period,
    input  logic [7:0] thresh0,
    input  logic [7:0] thresh1,
    input  logic       clear_err,
    output logic       qtr_en0,
    output logic       qtr_en1,
    input  logic [7:0] value0,
    input  logic [7:0] value1,
    input  logic       valid0,
    input  logic       valid1,
    output logic [7:0] sample0,
    output logic [7:0] sample1,
    output logic [1:0] detect,
    output logic       update,
    output logic       timeout_err
);

    localparam int              TICK      = CLK_FREQUENCY / 1000;
    localparam int              PW        = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK - 1);
    localparam logic [7:0]      TO_LIM    = 8'(TIMEOUT_MS);

    typedef enum logic [2:0] {IDLE, WAIT, FIRE, COLLECT, COMMIT} state_t;

    state_t      state, state_n;
    logic [PW-1:0] pre;
    logic        ms_tick;
    logic [7:0]  ms_cnt;
    logic        got0, got1, got0_n, got1_n, take0, take1;
    logic [7:0]  hold0, hold1, hold0_n, hold1_n;
    logic [7:0]  per_eff, s0_n, s1_n;
    logic        both_n, timed_out, commit_go, to_set;

    // ms prescaler, free-running from reset
    assign ms_tick = (pre == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pre <= '0;
        else        pre <= ms_tick ? '0 : pre + 1'b1;
    end

    // ms ticks since the last FIRE; saturates so a long wait never wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         ms_cnt <= '0;
        else if (state == FIRE)             ms_cnt <= '0;
        else if (ms_tick && ms_cnt != 8'hFF) ms_cnt <= ms_cnt + 8'd1;
    end

    // Result capture: first strobe per channel wins, later ones are dropped
    assign take0   = (state == COLLECT) && valid0 && !got0;
    assign take1   = (state == COLLECT) && valid1 && !got1;
    assign got0_n  = got0 | take0;
    assign got1_n  = got1 | take1;
    assign hold0_n = take0 ? value0 : hold0;
    assign hold1_n = take1 ? value1 : hold1;
    assign both_n  = got0_n && got1_n;

    assign timed_out = (ms_cnt >= TO_LIM);
    assign per_eff   = (period == 8'd0) ? 8'd1 : period;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            got0  <= 1'b0;
            got1  <= 1'b0;
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            got0  <= (state == FIRE) ? 1'b0 : got0_n;
            got1  <= (state == FIRE) ? 1'b0 : got1_n;
            hold0 <= hold0_n;
            hold1 <= hold1_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (enable) state_n = FIRE;
            WAIT:    if (!enable)                state_n = IDLE;
                     else if (ms_cnt >= per_eff) state_n = FIRE;
            FIRE:    state_n = COLLECT;
            // Capture and exit share an edge so update lands one cycle after the last strobe
            COLLECT: if (both_n || timed_out) state_n = COMMIT;
            COMMIT:  state_n = WAIT;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered on entry to FIRE/COMMIT so they are valid during that state
    assign commit_go = (state == COLLECT) && (state_n == COMMIT);
    assign to_set    = commit_go && !both_n;
    assign s0_n      = got0_n ? hold0_n : 8'hFF;
    assign s1_n      = got1_n ? hold1_n : 8'hFF;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qtr_en0     <= 1'b0;
            qtr_en1     <= 1'b0;
            update      <= 1'b0;
            sample0     <= '0;
            sample1     <= '0;
            detect      <= '0;
            timeout_err <= 1'b0;
        end else begin
            qtr_en0 <= (state_n == FIRE);
            qtr_en1 <= (state_n == FIRE);
            update  <= commit_go;
            if (commit_go) begin
                sample0 <= s0_n;
                sample1 <= s1_n;
                detect  <= {s1_n >= thresh1, s0_n >= thresh0};
            end
            // set has priority over a coincident clear
            if (to_set)         timeout_err <= 1'b1;
            else if (clear_err) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qtr_sched.sv
// Directed bench for qtr_sched with a 60-cycle ms tick (CLK_FREQUENCY=60_000).
// Edge counter ec counts rising edges since reset release; after each edge the
// bench waits #1 before driving or checking. With the prescaler starting at
// release, ms ticks are counted at edges 60, 120, 180, ...
module tb_qtr_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] period = 8'd0;
    logic [7:0] thresh0 = 8'd50;
    logic [7:0] thresh1 = 8'd50;
    logic       clear_err = 1'b0;
    logic [7:0] value0 = 8'd0;
    logic [7:0] value1 = 8'd0;
    logic       valid0 = 1'b0;
    logic       valid1 = 1'b0;
    logic       qtr_en0, qtr_en1, update, timeout_err;
    logic [7:0] sample0, sample1;
    logic [1:0] detect;

    int tests = 0;
    int fails = 0;
    int ec    = 0;

    qtr_sched #(.CLK_FREQUENCY(60_000), .TIMEOUT_MS(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .period(period),
        .thresh0(thresh0), .thresh1(thresh1), .clear_err(clear_err),
        .qtr_en0(qtr_en0), .qtr_en1(qtr_en1),
        .value0(value0), .value1(value1), .valid0(valid0), .valid1(valid1),
        .sample0(sample0), .sample1(sample1), .detect(detect),
        .update(update), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        ec++;
    endtask

    task automatic do_reset(input logic en, input logic [7:0] per);
        reset = 1'b0; enable = en; period = per; clear_err = 1'b0;
        valid0 = 1'b0; valid1 = 1'b0; value0 = 8'd0; value1 = 8'd0;
        repeat (3) step();
        #2;
        reset = 1'b1;
        ec = 0;
    endtask

    task automatic test_reset();
        logic [22:0] outs;
        reset = 1'b0;
        repeat (2) step();
        outs = {qtr_en0, qtr_en1, update, timeout_err, detect, sample0, sample1};
        tests++;
        if (outs !== 23'd0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        do_reset(1'b0, 8'd1);
        repeat (3) step();
        tests++;
        if ({qtr_en0, qtr_en1} !== 2'b00) begin fails++; $display("FAIL reset_idle_no_fire: got %b expected 00", {qtr_en0, qtr_en1}); end
        enable = 1'b1;
        step();
        tests++;
        if ({qtr_en0, qtr_en1} !== 2'b11) begin fails++; $display("FAIL reset_enable_fire: got %b expected 11", {qtr_en0, qtr_en1}); end
        step();
        tests++;
        if ({qtr_en0, qtr_en1} !== 2'b00) begin fails++; $display("FAIL reset_fire_one_cycle: got %b expected 00", {qtr_en0, qtr_en1}); end
    endtask

    task automatic test_basic();
        thresh0 = 8'd50; thresh1 = 8'd50;
        do_reset(1'b1, 8'd2);
        step();
        tests++;
        if ({qtr_en0, qtr_en1} !== 2'b11) begin fails++; $display("FAIL basic_first_fire: got %b expected 11", {qtr_en0, qtr_en1}); end
        while (ec < 11) step();
        valid0 = 1'b1; value0 = 8'd100;
        step();
        valid0 = 1'b0;
        while (ec < 14) step();
        valid0 = 1'b1; value0 = 8'd200;   // repeat strobe, must be dropped
        step();
        valid0 = 1'b0;
        while (ec < 21) step();
        tests++;
        if (update !== 1'b0) begin fails++; $display("FAIL basic_no_early_update: got %b expected 0", update); end
        valid1 = 1'b1; value1 = 8'd30;
        step();
        valid1 = 1'b0;
        tests++;
        if (update !== 1'b1) begin fails++; $display("FAIL basic_update: got %b expected 1", update); end
        tests++;
        if (sample0 !== 8'd100) begin fails++; $display("FAIL basic_sample0: got %0d expected 100", sample0); end
        tests++;
        if (sample1 !== 8'd30) begin fails++; $display("FAIL basic_sample1: got %0d expected 30", sample1); end
        tests++;
        if (detect !== 2'b01) begin fails++; $display("FAIL basic_detect: got %b expected 01", detect); end
        step();
        tests++;
        if (update !== 1'b0) begin fails++; $display("FAIL basic_update_one_cycle: got %b expected 0", update); end
        while (!qtr_en0 && ec < 400) step();
        tests++;
        if (ec !== 121) begin fails++; $display("FAIL basic_period_spacing: got edge %0d expected 121", ec); end
    endtask

    task automatic test_simultaneous();
        thresh0 = 8'd50; thresh1 = 8'd50;
        do_reset(1'b1, 8'd2);
        while (ec < 5) step();
        valid0 = 1'b1; valid1 = 1'b1; value0 = 8'd7; value1 = 8'd9;
        step();
        valid0 = 1'b0; valid1 = 1'b0;
        tests++;
        if ({update, sample0, sample1} !== {1'b1, 8'd7, 8'd9}) begin
            fails++; $display("FAIL simul_commit: got upd=%b s0=%0d s1=%0d expected upd=1 s0=7 s1=9", update, sample0, sample1);
        end
        tests++;
        if (detect !== 2'b00) begin fails++; $display("FAIL simul_detect: got %b expected 00", detect); end
        step();
        tests++;
        if (update !== 1'b0) begin fails++; $display("FAIL simul_single_update: got %b expected 0", update); end
    endtask

    task automatic test_timeout();
        thresh0 = 8'd50; thresh1 = 8'd50;
        do_reset(1'b1, 8'd2);
        while (ec < 10) step();
        valid0 = 1'b1; value0 = 8'd40;
        step();
        valid0 = 1'b0;
        while (ec < 240) step();
        tests++;
        if (update !== 1'b0) begin fails++; $display("FAIL timeout_not_early: got %b expected 0", update); end
        step();
        tests++;
        if ({update, timeout_err} !== 2'b11) begin fails++; $display("FAIL timeout_commit: got upd/err=%b expected 11", {update, timeout_err}); end
        tests++;
        if ({sample0, sample1} !== {8'd40, 8'd255}) begin
            fails++; $display("FAIL timeout_samples: got s0=%0d s1=%0d expected s0=40 s1=255", sample0, sample1);
        end
        tests++;
        if (detect !== 2'b10) begin fails++; $display("FAIL timeout_detect: got %b expected 10", detect); end
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        tests++;
        if (timeout_err !== 1'b0) begin fails++; $display("FAIL timeout_clear: got %b expected 0", timeout_err); end
        // next sample fires at edge 243 and times out at edge 481; clear coincides
        while (ec < 480) step();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        tests++;
        if ({update, timeout_err} !== 2'b11) begin fails++; $display("FAIL timeout_set_beats_clear: got upd/err=%b expected 11", {update, timeout_err}); end
        tests++;
        if ({sample0, sample1} !== {8'd255, 8'd255}) begin
            fails++; $display("FAIL timeout_both_missing: got s0=%0d s1=%0d expected 255 255", sample0, sample1);
        end
    endtask

    task automatic test_period_zero();
        thresh0 = 8'd40; thresh1 = 8'd30;
        do_reset(1'b1, 8'd0);
        while (ec < 5) step();
        valid0 = 1'b1; valid1 = 1'b1; value0 = 8'd40; value1 = 8'd30;
        step();
        valid0 = 1'b0; valid1 = 1'b0;
        tests++;
        if ({update, detect} !== 3'b111) begin fails++; $display("FAIL p0_detect_equal: got upd/det=%b expected 111", {update, detect}); end
        while (!qtr_en0 && ec < 200) step();
        tests++;
        if (ec !== 61) begin fails++; $display("FAIL p0_spacing: got edge %0d expected 61", ec); end
    endtask

    task automatic test_reset_mid_collect();
        int upd_seen;
        thresh0 = 8'd50; thresh1 = 8'd50;
        do_reset(1'b1, 8'd0);
        while (ec < 5) step();
        valid0 = 1'b1; valid1 = 1'b1; value0 = 8'd200; value1 = 8'd210;
        step();
        valid0 = 1'b0; valid1 = 1'b0;
        while (ec < 70) step();          // second sample in COLLECT since edge 62
        valid0 = 1'b1; value0 = 8'd99;
        step();
        valid0 = 1'b0;
        while (ec < 75) step();
        tests++;
        if ({sample0, sample1, detect} !== {8'd200, 8'd210, 2'b11}) begin
            fails++; $display("FAIL rmid_pre_state: got s0=%0d s1=%0d det=%b expected 200 210 11", sample0, sample1, detect);
        end
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if ({qtr_en0, qtr_en1, update, timeout_err, detect, sample0, sample1} !== 23'd0) begin
            fails++; $display("FAIL rmid_async_clear: got s0=%0d s1=%0d det=%b expected all 0", sample0, sample1, detect);
        end
        upd_seen = 0;
        valid1 = 1'b1; value1 = 8'd5;
        repeat (4) begin step(); if (update) upd_seen++; end
        valid1 = 1'b0;
        #2;
        reset = 1'b1;
        ec = 0;
        step();
        tests++;
        if ({qtr_en0, qtr_en1} !== 2'b11) begin fails++; $display("FAIL rmid_first_fire: got %b expected 11", {qtr_en0, qtr_en1}); end
        repeat (10) begin step(); if (update) upd_seen++; end
        tests++;
        if (upd_seen !== 0) begin fails++; $display("FAIL rmid_no_update: got %0d pulses expected 0", upd_seen); end
    endtask

    task automatic test_enable_drop();
        int fires;
        thresh0 = 8'd50; thresh1 = 8'd50;
        do_reset(1'b1, 8'd1);
        while (ec < 3) step();
        enable = 1'b0;
        while (ec < 5) step();
        valid0 = 1'b1; valid1 = 1'b1; value0 = 8'd60; value1 = 8'd10;
        step();
        valid0 = 1'b0; valid1 = 1'b0;
        tests++;
        if ({update, sample0, sample1, detect} !== {1'b1, 8'd60, 8'd10, 2'b01}) begin
            fails++; $display("FAIL endrop_commit: got upd=%b s0=%0d s1=%0d det=%b expected 1 60 10 01", update, sample0, sample1, detect);
        end
        fires = 0;
        repeat (300) begin step(); if (qtr_en0 || qtr_en1) fires++; end
        tests++;
        if (fires !== 0) begin fails++; $display("FAIL endrop_no_fire: got %0d pulses expected 0", fires); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_simultaneous();
        test_timeout();
        test_period_zero();
        test_reset_mid_collect();
        test_enable_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/qtr_sched.md
QTR_SCHED -- requirements
Module: qtr_sched

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY, default 60_000_000, meaning clk rate in Hz; one ms tick = CLK_FREQUENCY/1000 cycles.
REQ-002 SHALL have parameter TIMEOUT_MS, default 4, meaning ms allowed from trigger to both sensor results.
REQ-003 SHALL have port clk  in  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port enable  in  1  level; 1 = periodic sampling runs.
REQ-006 SHALL have port period  in  8  sample period in ms; 0 treated as 1.
REQ-007 SHALL have port thresh0 / thresh1  in  8 each  detect thresholds, channel 0/1.
REQ-008 SHALL have port clear_err  in  1  one-cycle pulse clearing timeout_err.
REQ-009 SHALL have port qtr_en0 / qtr_en1  out  1 each  one-cycle start pulse to each qtr sensor stage.
REQ-010 SHALL have port value0 / value1  in  8 each  decay time from qtr stage, 10 us units.
REQ-011 SHALL have port valid0 / valid1  in  1 each  one-cycle result strobe from qtr stage.
REQ-012 SHALL have port sample0 / sample1  out  8 each  last committed values.
REQ-013 SHALL have port detect  out  2  bit n = 1 when sampleN >= threshN at commit.
REQ-014 SHALL have port update  out  1  one-cycle pulse when sample0/1 and detect change.
REQ-015 SHALL have port timeout_err  out  1  sticky timeout flag.

Function
REQ-016 SHALL run a ms prescaler that emits a one-cycle ms_tick every CLK_FREQUENCY/1000 cycles, free-running out of reset.
REQ-017 SHALL implement states IDLE, WAIT, FIRE, COLLECT, COMMIT.
REQ-018 SHALL go IDLE -> FIRE on the cycle after enable=1 is sampled.
REQ-019 SHALL in FIRE assert qtr_en0 and qtr_en1 high together for exactly one cycle, clear got0/got1 flags, clear the ms-tick counter, then enter COLLECT.
REQ-020 SHALL in COLLECT latch value0 into a holding register and set got0 on valid0; same for channel 1; simultaneous valid0 and valid1 SHALL both be latched.
REQ-021 SHALL ignore a second valid on an already-latched channel within one COLLECT.
REQ-022 SHALL leave COLLECT for COMMIT the cycle after got0 and got1 are both set.
REQ-023 SHALL leave COLLECT for COMMIT once TIMEOUT_MS ms_ticks have counted since FIRE; missing channels SHALL be given value 255, and timeout_err SHALL be set.
REQ-024 SHALL in COMMIT, for one cycle, load sample0/1 from the holding registers, compute detect with 8-bit unsigned >= compare, and pulse update high in the same cycle as the new values appear.
REQ-025 SHALL go COMMIT -> WAIT, and WAIT -> FIRE when the ms-tick count since FIRE reaches max(period,1); if that count is already reached on WAIT entry, FIRE SHALL follow next cycle.
REQ-026 SHALL ignore valid0/valid1 outside COLLECT.
REQ-027 SHALL, on enable=0, move from WAIT to IDLE; in FIRE/COLLECT/COMMIT the current sample SHALL complete, and WAIT then SHALL go to IDLE.
REQ-028 SHALL sample period at each WAIT evaluation; a change takes effect for the current wait.
REQ-029 SHALL clear timeout_err on clear_err; simultaneous timeout set and clear_err SHALL leave timeout_err = 1.

Reset
REQ-030 SHALL, while reset=0, force state IDLE, prescaler, ms counter, got flags and holding registers to 0, sample0/1 = 0, detect = 0, update = 0, qtr_en0/1 = 0, timeout_err = 0.
REQ-031 SHALL take reset asynchronously at any state, including mid-COLLECT; no update pulse SHALL follow a reset-interrupted cycle.
REQ-032 SHALL treat the first rising clk edge after reset=1 as a normal IDLE cycle.

Verification (CLK_FREQUENCY=60_000 -> 60-cycle ms tick)
REQ-033 SHALL cover: enable=1, period=2, valid0 value0=100 at +10 cycles, valid1 value1=30 at +20 cycles, thresh0=thresh1=50 -> update one cycle after the valid1 cycle, sample0=100, sample1=30, detect=2'b01, next qtr_en pulse 120 cycles after the first.
REQ-034 SHALL cover: valid0 and valid1 in the same cycle, values 7 and 9 -> both latched, sample0=7, sample1=9, single update pulse.
REQ-035 SHALL cover: only valid0 (value 40) returned, TIMEOUT_MS=4 -> COMMIT at 240 ticks-cycles, sample1=255, timeout_err=1; clear_err pulse -> timeout_err=0.
REQ-036 SHALL cover: period=0 -> trigger spacing 60 cycles (same as period=1); value=thresh exactly -> detect bit 1.
REQ-037 SHALL cover: reset=0 asserted mid-COLLECT -> all outputs 0 immediately, no update; after release with enable=1, first qtr_en pulse two cycles later.
REQ-038 SHALL cover: enable dropped during COLLECT -> that sample commits with update, then no further qtr_en pulses.
